// File: rtl/ama_riscv_mmio_responder.sv
// MMIO responder: TOHOST/SCRATCH registers plus a 64-bit cycle counter with a HI shadow,
// served over a valid/ready request/response pair with a fixed response latency.
module ama_riscv_mmio_responder #(
    parameter int AW      = 16,
    parameter int RSP_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_we,
    input  logic [3:0]    req_wmask,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    output logic [31:0]   tohost,
    output logic          tohost_wr
);

    localparam logic [1:0] MMIO_RANGE   = 2'b01;
    localparam logic [2:0] OFF_TOHOST   = 3'd0;
    localparam logic [2:0] OFF_SCRATCH  = 3'd1;
    localparam logic [2:0] OFF_CYCLE_LO = 3'd2;
    localparam logic [2:0] OFF_CYCLE_HI = 3'd3;
    localparam bit         LAT_ONE      = (RSP_LAT <= 1);
    localparam logic [3:0] LAT_LOAD     = 4'((RSP_LAT >= 2) ? (RSP_LAT - 2) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Byte-lane merge of new write data into an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t      r_state;
    logic [3:0]  r_lat_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic [31:0] r_tohost;
    logic        r_tohost_wr;
    logic [31:0] r_scratch;
    logic [63:0] r_cnt;
    logic [31:0] r_cnt_hi_shadow;

    logic        w_accept;
    logic        w_in_range;
    logic [2:0]  w_off;
    logic        w_err;
    logic [31:0] w_rdata;
    logic        w_wr_tohost;
    logic        w_wr_scratch;
    logic        w_rd_cycle_lo;
    logic        w_unused_addr;

    assign w_unused_addr = ^{req_addr[AW-3:5], req_addr[1:0]};

    // Request decode and read-data mux, evaluated on the accept cycle.
    always_comb begin
        w_accept      = req_valid && (r_state == S_IDLE);
        w_in_range    = (req_addr[AW-1:AW-2] == MMIO_RANGE);
        w_off         = req_addr[4:2];
        w_err         = !(w_in_range && (w_off <= OFF_CYCLE_HI));
        w_rdata       = 32'd0;
        case (w_off)
            OFF_TOHOST:   w_rdata = r_tohost;
            OFF_SCRATCH:  w_rdata = r_scratch;
            OFF_CYCLE_LO: w_rdata = r_cnt[31:0];
            OFF_CYCLE_HI: w_rdata = r_cnt_hi_shadow;
            default:      w_rdata = 32'd0;
        endcase
        w_wr_tohost   = w_accept && req_we && !w_err && (w_off == OFF_TOHOST);
        w_wr_scratch  = w_accept && req_we && !w_err && (w_off == OFF_SCRATCH);
        w_rd_cycle_lo = w_accept && !req_we && !w_err && (w_off == OFF_CYCLE_LO);
    end

    // Handshake FSM; the response payload is captured once at accept and held.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lat_cnt   <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_rsp_data  <= (req_we || w_err) ? 32'd0 : w_rdata;
                        r_rsp_err   <= w_err;
                        r_lat_cnt   <= LAT_LOAD;
                        if (LAT_ONE) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                        end else begin
                            r_state     <= S_WAIT;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_lat_cnt   <= r_lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Architectural registers; writes commit on the accept edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tohost        <= 32'd0;
            r_tohost_wr     <= 1'b0;
            r_scratch       <= 32'd0;
            r_cnt_hi_shadow <= 32'd0;
        end else begin
            r_tohost_wr <= w_wr_tohost;
            if (w_wr_tohost) begin
                r_tohost <= merge_bytes(r_tohost, req_wdata, req_wmask);
            end else begin
                r_tohost <= r_tohost;
            end
            if (w_wr_scratch) begin
                r_scratch <= merge_bytes(r_scratch, req_wdata, req_wmask);
            end else begin
                r_scratch <= r_scratch;
            end
            // Shadow the upper half so a LO-then-HI read pair is coherent.
            if (w_rd_cycle_lo) begin
                r_cnt_hi_shadow <= r_cnt[63:32];
            end else begin
                r_cnt_hi_shadow <= r_cnt_hi_shadow;
            end
        end
    end

    // Free-running 64-bit cycle counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 64'd0;
        end else begin
            r_cnt <= r_cnt + 64'd1;
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign tohost    = r_tohost;
    assign tohost_wr = r_tohost_wr;

endmodule

// File: tb/tb_ama_riscv_mmio_responder.sv
// Directed bench: one RSP_LAT=1 instance for function/decode/counter/reset and one RSP_LAT=3
// instance for latency and backpressure.
module tb_ama_riscv_mmio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [15:0] req_addr = 16'd0;
    logic [3:0]  req_wmask = 4'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_err, tohost_wr;
    logic [31:0] rsp_data, tohost;

    logic        req_valid3 = 1'b0, req_we3 = 1'b0, rsp_ready3 = 1'b1;
    logic [15:0] req_addr3 = 16'd0;
    logic [3:0]  req_wmask3 = 4'd0;
    logic [31:0] req_wdata3 = 32'd0;
    logic        req_ready3, rsp_valid3, rsp_err3, tohost_wr3;
    logic [31:0] rsp_data3, tohost3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ama_riscv_mmio_responder #(.AW(16), .RSP_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .tohost(tohost), .tohost_wr(tohost_wr)
    );

    ama_riscv_mmio_responder #(.AW(16), .RSP_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_addr(req_addr3),
        .req_we(req_we3), .req_wmask(req_wmask3), .req_wdata(req_wdata3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .rsp_err(rsp_err3), .tohost(tohost3), .tohost_wr(tohost_wr3)
    );

    // One request on the RSP_LAT=1 instance with rsp_ready held high; returns latency in cycles.
    task automatic txn1(input logic [15:0] addr, input logic we, input logic [3:0] mask,
                        input logic [31:0] wdata, output logic [31:0] data,
                        output logic err, output int lat);
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = addr; req_we = we; req_wmask = mask; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; data = 32'd0; err = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                lat = k; data = rsp_data; err = rsp_err;
                break;
            end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL txn1_timeout: addr %h no rsp_valid within 20 cycles", addr);
        end
    endtask

    // TOHOST write checking the single-cycle tohost_wr pulse and resulting value.
    task automatic tohost_write(input logic [3:0] mask, input logic [31:0] wdata,
                                input logic [31:0] want);
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 16'h4000; req_we = 1'b1; req_wmask = mask; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (tohost_wr !== 1'b1) begin bad++; $display("FAIL tohost_wr_pulse: got %b want 1", tohost_wr); end
        total++; if (tohost !== want) begin bad++; $display("FAIL tohost_val: got %h want %h", tohost, want); end
        @(negedge clk);
        total++; if (tohost_wr !== 1'b0) begin bad++; $display("FAIL tohost_wr_single: got %b want 0", tohost_wr); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL tohost_rsp_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        total++; if (req_ready3 !== 1'b1) begin bad++; $display("FAIL rst_req_ready3: got %b want 1", req_ready3); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        total++; if (rsp_data !== 32'd0) begin bad++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        total++; if (tohost !== 32'd0) begin bad++; $display("FAIL rst_tohost: got %h want 0", tohost); end
        total++; if (tohost_wr !== 1'b0) begin bad++; $display("FAIL rst_tohost_wr: got %b want 0", tohost_wr); end
    endtask

    task automatic test_write_read();
        logic [31:0] d; logic e; int lat;
        txn1(16'h4004, 1'b1, 4'hF, 32'hDEADBEEF, d, e, lat);
        total++; if (lat !== 1) begin bad++; $display("FAIL wr_latency: got %0d want 1", lat); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL wr_data: got %h want 0", d); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", e); end
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL busy_req_ready: got %b want 0", req_ready); end
        txn1(16'h4004, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_scratch: got %h want deadbeef", d); end
        total++; if (lat !== 1) begin bad++; $display("FAIL rd_latency: got %0d want 1", lat); end
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_hs: got %b want 1", req_ready); end
    endtask

    task automatic test_wmask();
        logic [31:0] d; logic e; int lat;
        txn1(16'h4004, 1'b1, 4'b0101, 32'h11223344, d, e, lat);
        txn1(16'h4004, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'hDE22BE44) begin bad++; $display("FAIL wmask_merge: got %h want de22be44", d); end
        txn1(16'h4004, 1'b1, 4'b0000, 32'hFFFFFFFF, d, e, lat);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL wmask0_err: got %b want 0", e); end
        txn1(16'h4007, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'hDE22BE44) begin bad++; $display("FAIL wmask0_noop: got %h want de22be44", d); end
    endtask

    task automatic test_tohost_decode();
        logic [31:0] d; logic e; int lat;
        tohost_write(4'hF, 32'h00000001, 32'h00000001);
        tohost_write(4'h0, 32'hFFFFFFFF, 32'h00000001);
        txn1(16'h0000, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", e); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL oor_data: got %h want 0", d); end
        txn1(16'h4010, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL unmapped_err: got %b want 1", e); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_data: got %h want 0", d); end
        txn1(16'h0000, 1'b1, 4'hF, 32'h55555555, d, e, lat);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL oor_wr_err: got %b want 1", e); end
        total++; if (tohost !== 32'h00000001) begin bad++; $display("FAIL tohost_kept: got %h want 1", tohost); end
        txn1(16'h4014, 1'b1, 4'hF, 32'h99999999, d, e, lat);
        txn1(16'h4004, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'hDE22BE44) begin bad++; $display("FAIL unmapped_wr_nostate: got %h want de22be44", d); end
        txn1(16'h4000, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'h00000001) begin bad++; $display("FAIL tohost_read: got %h want 1", d); end
        txn1(16'h4008, 1'b1, 4'hF, 32'h12345678, d, e, lat);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL cycle_wr_err: got %b want 0", e); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL cycle_wr_data: got %h want 0", d); end
    endtask

    task automatic test_cycle_counter();
        logic [31:0] d; logic e; int lat;
        force u_dut1.r_cnt = 64'h0000_0000_FFFF_FFFE;
        txn1(16'h4008, 1'b0, 4'h0, 32'd0, d, e, lat);
        release u_dut1.r_cnt;
        total++; if (d !== 32'hFFFFFFFE) begin bad++; $display("FAIL cycle_lo: got %h want fffffffe", d); end
        repeat (4) @(negedge clk);
        txn1(16'h400C, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL cycle_hi_shadow: got %h want 0", d); end
        txn1(16'h4008, 1'b0, 4'h0, 32'd0, d, e, lat);
        txn1(16'h400C, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'd1) begin bad++; $display("FAIL cycle_hi_after_lo: got %h want 1", d); end
    endtask

    task automatic test_latency_backpressure();
        int first;
        @(negedge clk);
        rsp_ready3 = 1'b1;
        req_valid3 = 1'b1; req_addr3 = 16'h4004; req_we3 = 1'b1; req_wmask3 = 4'hF; req_wdata3 = 32'hA5A55A5A;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (rsp_valid3 === 1'b1) begin first = k; break; end
        end
        total++; if (first !== 3) begin bad++; $display("FAIL lat3_write: got %0d want 3", first); end
        @(negedge clk);
        total++; if (req_ready3 !== 1'b1) begin bad++; $display("FAIL lat3_ready_after: got %b want 1", req_ready3); end
        rsp_ready3 = 1'b0;
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'h4004;
        @(posedge clk);
        #1 req_we3 = 1'b1; req_wdata3 = 32'h00000000;
        first = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (req_ready3 !== 1'b0) begin
                total++; bad++; $display("FAIL lat3_ready_busy: got %b want 0 at cycle %0d", req_ready3, k);
            end
            if (rsp_valid3 === 1'b1) begin first = k; break; end
        end
        total++; if (first !== 3) begin bad++; $display("FAIL lat3_read: got %0d want 3", first); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++; if (rsp_valid3 !== 1'b1 || rsp_data3 !== 32'hA5A55A5A || req_ready3 !== 1'b0) begin
                bad++; $display("FAIL lat3_hold: got v=%b d=%h r=%b want v=1 d=a5a55a5a r=0", rsp_valid3, rsp_data3, req_ready3);
            end
        end
        req_valid3 = 1'b0; rsp_ready3 = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid3 !== 1'b0 || req_ready3 !== 1'b1) begin
            bad++; $display("FAIL lat3_idle_after_hs: got v=%b r=%b want v=0 r=1", rsp_valid3, req_ready3);
        end
        req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'h4004;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (rsp_valid3 !== 1'b1 || rsp_data3 !== 32'hA5A55A5A) begin
            bad++; $display("FAIL lat3_busy_write_ignored: got v=%b d=%h want v=1 d=a5a55a5a", rsp_valid3, rsp_data3);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_resp();
        logic [31:0] d; logic e; int lat;
        txn1(16'h4004, 1'b1, 4'hF, 32'h12345678, d, e, lat);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4004;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rresp_pending: got %b want 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rresp_valid_cleared: got %b want 0", rsp_valid); end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++; $display("FAIL rresp_no_stale: got v=%b r=%b want v=0 r=1", rsp_valid, req_ready);
            end
        end
        txn1(16'h4004, 1'b0, 4'h0, 32'd0, d, e, lat);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rresp_scratch: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wmask();
        test_tohost_decode();
        test_cycle_counter();
        test_latency_backpressure();
        test_reset_in_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ama_riscv_mmio_responder.md
AMA_RISCV_MMIO_RESPONDER -- requirements
Module: ama_riscv_mmio_responder

Interface
REQ-001 Parameter AW, default 16: request byte-address width; equals CORE_ADDR_BUS_B.
REQ-002 Parameter RSP_LAT, default 1: cycles from request accept to first rsp_valid; legal range 1..15.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  initiator request valid.
REQ-007 req_ready  out  1  responder can accept a request.
REQ-008 req_addr  in  AW  byte address.
REQ-009 req_we  in  1  1 = write, 0 = read.
REQ-010 req_wmask  in  4  byte enables for writes; bit i enables wdata[8i+7:8i].
REQ-011 req_wdata  in  32  write data.
REQ-012 rsp_valid  out  1  response valid.
REQ-013 rsp_ready  in  1  initiator accepts response.
REQ-014 rsp_data  out  32  read data; 0 for writes and errors.
REQ-015 rsp_err  out  1  request decoded outside MMIO range or to an unmapped offset.
REQ-016 tohost  out  32  current TOHOST register value.
REQ-017 tohost_wr  out  1  one-cycle pulse, cycle after a TOHOST write is accepted.

Function
REQ-018 Accept = req_valid && req_ready; req_ready SHALL be 1 only in IDLE, so at most one request is outstanding.
REQ-019 FSM states: IDLE -> (accept) WAIT -> (latency counter done) RESP -> (rsp_valid && rsp_ready) IDLE; when RSP_LAT=1, WAIT lasts 0 cycles and the FSM goes IDLE -> RESP.
REQ-020 rsp_valid SHALL rise exactly RSP_LAT cycles after the accept edge and SHALL hold, with stable rsp_data and rsp_err, until rsp_ready=1.
REQ-021 After the response handshake, req_ready SHALL be 1 in the next cycle. Peak throughput is one request per RSP_LAT+1 cycles.
REQ-022 Decode: in range iff req_addr[AW-1:AW-2] == MMIO_RANGE (2'b01); offset = req_addr[4:2]; req_addr[1:0] ignored.
REQ-023 Register map: 0x00 TOHOST (RW), 0x04 SCRATCH (RW), 0x08 CYCLE_LO (RO), 0x0C CYCLE_HI (RO). Offsets 0x10-0x1C are unmapped.
REQ-024 Out-of-range or unmapped access SHALL complete normally with rsp_err=1, rsp_data=0, and no state change.
REQ-025 Writes SHALL commit on the accept edge, per byte under req_wmask; wmask=0 is a legal no-op.
REQ-026 A write to CYCLE_LO/HI SHALL be ignored with rsp_err=0.
REQ-027 tohost_wr SHALL pulse for any accepted in-range TOHOST write, including wmask=0.
REQ-028 Reads SHALL sample register values at the accept cycle; rsp_data is registered and does not change while waiting.
REQ-029 Cycle counter: 64 bits, +1 every cycle after reset, wraps 2^64-1 -> 0.
REQ-030 A CYCLE_LO read SHALL return cnt[31:0] and latch cnt[63:32] into a HI shadow in the same cycle.
REQ-031 A CYCLE_HI read SHALL return the HI shadow, not the live counter.
REQ-032 req_* inputs SHALL be ignored outside IDLE.

Reset
REQ-033 Reset values: state IDLE, req_ready 1 the first cycle after reset deasserts, rsp_valid 0, rsp_data 0, rsp_err 0, tohost 0, tohost_wr 0, SCRATCH 0, counter 0, HI shadow 0.
REQ-034 Reset in WAIT or RESP SHALL discard the in-flight response; no rsp_valid appears after reset.

Verification
REQ-035 RSP_LAT=1: write 0x0000_4004, wdata 0xDEADBEEF, wmask 4'hF, then read 0x4004 -> first rsp_valid 1 cycle after accept, data 0, err 0; read returns 0xDEADBEEF.
REQ-036 SCRATCH=0xDEADBEEF, write wmask 4'b0101, wdata 0x11223344 -> read returns 0xDE22BE44.
REQ-037 Write 0x4000 with wdata 1 -> tohost=1 and a single-cycle tohost_wr; read 0x0000 -> err 1, data 0; read 0x4010 -> err 1; TOHOST unchanged.
REQ-038 RSP_LAT=3, rsp_ready held 0 for 5 cycles -> rsp_valid rises 3 cycles after accept, holds stable data, req_ready=0 throughout, IDLE the cycle after handshake.
REQ-039 Force the counter to 0x0000_0000_FFFF_FFFE -> read CYCLE_LO returns 0xFFFF_FFFE; after the counter wraps, CYCLE_HI returns shadow 0, not 1.
REQ-040 Assert rst during RESP -> rsp_valid 0 the next cycle, no stale response, SCRATCH 0.
